// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement of out-of-order completions, with a
// branch flush that squashes every entry younger than the flushing tag.
module reorder_buffer #(
    parameter int PREG_WIDTH = 7,
    parameter int ROB_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dispatch_valid,
    input  logic [ROB_WIDTH-1:0]  dispatch_rob_tag,
    input  logic                  dispatch_has_dest,
    input  logic [PREG_WIDTH-1:0] dispatch_old_prd,
    input  logic [PREG_WIDTH-1:0] dispatch_prd,
    output logic                  rob_ready,
    output logic                  rob_empty,
    input  logic                  wb_valid,
    input  logic [ROB_WIDTH-1:0]  wb_rob_tag,
    input  logic                  flush_valid,
    input  logic [ROB_WIDTH-1:0]  flush_tag,
    output logic                  commit_retire,
    output logic                  commit_en,
    output logic [PREG_WIDTH-1:0] commit_old_preg,
    output logic [PREG_WIDTH-1:0] commit_prd,
    output logic                  tag_error
);
    localparam int                 DEPTH    = 2 ** ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] FULL_CNT = (ROB_WIDTH+1)'(DEPTH);

    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0]      r_done;
    logic [DEPTH-1:0]      r_has_dest;
    logic [PREG_WIDTH-1:0] r_old_prd [DEPTH];
    logic [PREG_WIDTH-1:0] r_prd     [DEPTH];
    logic [ROB_WIDTH-1:0]  r_head;
    logic [ROB_WIDTH-1:0]  r_tail;
    logic [ROB_WIDTH:0]    r_count;
    logic                  r_tag_error;

    logic                  w_retire;
    logic                  w_dispatch;
    logic                  w_flush;
    logic [ROB_WIDTH-1:0]  w_flush_dist;
    logic [DEPTH-1:0]      w_squash;
    logic [ROB_WIDTH:0]    w_count_next;

    assign rob_ready    = (r_count != FULL_CNT);
    assign rob_empty    = (r_count == '0);
    assign w_retire     = r_valid[r_head] && r_done[r_head];
    assign w_dispatch   = dispatch_valid && rob_ready && !flush_valid;
    assign w_flush      = flush_valid && r_valid[flush_tag];
    assign w_flush_dist = flush_tag - r_head;

    // An entry is younger than the branch when its age (distance from head)
    // exceeds the branch's age; the head itself is never squashed.
    for (genvar g = 0; g < DEPTH; g++) begin : g_squash
        logic [ROB_WIDTH-1:0] w_dist;
        assign w_dist      = ROB_WIDTH'(g) - r_head;
        assign w_squash[g] = w_flush && (w_dist > w_flush_dist);
    end

    always_comb begin
        w_count_next = r_count;
        if (w_flush)
            w_count_next = {1'b0, w_flush_dist} + (ROB_WIDTH+1)'(1) - (ROB_WIDTH+1)'(w_retire);
        else
            w_count_next = r_count + (ROB_WIDTH+1)'(w_dispatch) - (ROB_WIDTH+1)'(w_retire);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid     <= '0;
            r_done      <= '0;
            r_has_dest  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_old_prd[i] <= '0;
                r_prd[i]     <= '0;
            end
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_tag_error <= 1'b0;
        end else begin
            if (wb_valid && r_valid[wb_rob_tag])
                r_done[wb_rob_tag] <= 1'b1;
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
                r_head          <= r_head + ROB_WIDTH'(1);
            end
            // Squash after writeback so a same-cycle completion of a squashed tag is lost.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_squash[i]) begin
                    r_valid[i] <= 1'b0;
                    r_done[i]  <= 1'b0;
                end
            end
            if (w_dispatch) begin
                r_valid[r_tail]    <= 1'b1;
                r_done[r_tail]     <= 1'b0;
                r_has_dest[r_tail] <= dispatch_has_dest;
                r_old_prd[r_tail]  <= dispatch_old_prd;
                r_prd[r_tail]      <= dispatch_prd;
                if (dispatch_rob_tag != r_tail)
                    r_tag_error <= 1'b1;
            end
            if (w_flush)
                r_tail <= flush_tag + ROB_WIDTH'(1);
            else if (w_dispatch)
                r_tail <= r_tail + ROB_WIDTH'(1);
            r_count <= w_count_next;
        end
    end

    assign commit_retire   = w_retire;
    assign commit_en       = w_retire && r_has_dest[r_head];
    assign commit_old_preg = w_retire ? r_old_prd[r_head] : '0;
    assign commit_prd      = w_retire ? r_prd[r_head] : '0;
    assign tag_error       = r_tag_error;

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter PREG_WIDTH, default 7, physical register index width.
REQ-002 Parameter ROB_WIDTH, default 4, tag width; depth DEPTH = 2**ROB_WIDTH entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 dispatch_valid  input  1  rename stage is delivering one instruction this cycle.
REQ-006 dispatch_rob_tag  input  ROB_WIDTH  tag allocated by rename for this instruction.
REQ-007 dispatch_has_dest  input  1  instruction writes a nonzero architectural rd.
REQ-008 dispatch_old_prd  input  PREG_WIDTH  previous mapping of rd, freed at commit.
REQ-009 dispatch_prd  input  PREG_WIDTH  newly allocated physical destination.
REQ-010 rob_ready  output  1  ROB can accept a dispatch this cycle.
REQ-011 rob_empty  output  1  no valid entries.
REQ-012 wb_valid  input  1  execution unit reports completion.
REQ-013 wb_rob_tag  input  ROB_WIDTH  tag of completing instruction.
REQ-014 flush_valid  input  1  squash all entries younger than flush_tag.
REQ-015 flush_tag  input  ROB_WIDTH  tag of mispredicted branch (branch itself is kept).
REQ-016 commit_retire  output  1  head entry retires this cycle.
REQ-017 commit_en  output  1  retiring entry has a destination; frees commit_old_preg.
REQ-018 commit_old_preg  output  PREG_WIDTH  old_prd of retiring entry.
REQ-019 commit_prd  output  PREG_WIDTH  prd of retiring entry (architectural map update).
REQ-020 tag_error  output  1  sticky flag: a dispatch arrived with tag != tail pointer.

Function
REQ-021 State: per entry valid, done, has_dest, old_prd, prd; head, tail (ROB_WIDTH bits, wrap mod DEPTH); count (ROB_WIDTH+1 bits, 0..DEPTH).
REQ-022 rob_ready = (count != DEPTH), from registered count only; rob_empty = (count == 0).
REQ-023 Dispatch accepted when dispatch_valid && rob_ready && !flush_valid: entry[tail] written valid=1, done=0, fields captured; tail increments.
REQ-024 Accepted dispatch with dispatch_rob_tag != tail sets tag_error (cleared only by reset); entry still written at tail.
REQ-025 Dispatch while full or during flush is dropped; no state change from it.
REQ-026 Writeback: wb_valid with entry[wb_rob_tag].valid sets done at the edge; writeback to invalid entry ignored.
REQ-027 commit_retire = entry[head].valid && entry[head].done, combinational from registers only; earliest retire is the cycle after writeback edge.
REQ-028 commit_en = commit_retire && entry[head].has_dest; commit_old_preg/commit_prd = entry[head] fields when commit_retire, else 0.
REQ-029 On retire: entry[head].valid cleared, head increments; at most one retire per cycle.
REQ-030 count next = count + accepted_dispatch - retire, except on flush.
REQ-031 Flush (flush_valid, entry[flush_tag] valid): entries from flush_tag+1 up to tail-1 (mod DEPTH) invalidated; tail = flush_tag+1; count = ((flush_tag - head) mod DEPTH) + 1 - retire.
REQ-032 Flush and retire in same cycle: head retires normally; if flush_tag == head, ROB becomes empty.
REQ-033 Flush with entry[flush_tag] invalid is ignored.
REQ-034 Writeback same cycle as flush to a squashed tag: entry ends invalid, done ignored.
REQ-035 Full DEPTH entries usable; wrap of head/tail from DEPTH-1 to 0 with no bubble.

Reset
REQ-036 While reset=0: head=tail=0, count=0, all valid/done=0, tag_error=0; outputs rob_ready=1, rob_empty=1, commit_retire=0, commit_en=0, commit_old_preg=0, commit_prd=0.
REQ-037 Reset asserted mid-operation discards all entries; no commit pulses after release until new dispatch+writeback.

Verification
REQ-038 Dispatch tags 0,1,2 (has_dest=1, old_prd 5,6,7); writeback 2,0,1 -> commit_en pulses in order old_preg 5,6,7; 5 starts the cycle after wb of tag 0.
REQ-039 Dispatch 16 with no writeback -> rob_ready=0 at count 16; 17th dispatch dropped; one retire -> rob_ready=1 next cycle.
REQ-040 Entries 0..5 valid, flush_tag=2 -> tail=3, count=3; writeback to tag 4 ignored; next dispatch accepted at tag 3.
REQ-041 Head=14 wrap: dispatch tags 14,15,0,1, all done -> retire 14,15,0,1 consecutive cycles, rob_empty=1 after.
REQ-042 Dispatch has_dest=0 done -> commit_retire=1, commit_en=0; dispatch tag 5 when tail=3 -> tag_error=1 until reset.
